muldiv_hazard_ctrl: RTL and testbench
=====================================

Name: muldiv_hazard_ctrl

Overview:
- Sequencer and hazard controller for the multi-cycle multiply/divide unit (MDU) in the EX stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu issue from ID/EX and pulses the MDU start.
- Counts the operation latency, then pulses the HI/LO write enable.
- Stalls IF/ID while a later mfhi/mflo or mult/div in ID would see stale or busy HI/LO. Stall outputs use the same polarity as the pipeline's load-use stall signals.

Parameters:
- MUL_CYCLES, 4, cycles spent in MUL state; legal range 1..63.
- DIV_CYCLES, 32, cycles spent in DIV state; legal range 1..63.
- CNT_W, 6, latency counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- start_mul_IDEX_i  input  1  mult/multu in EX this cycle.
- start_div_IDEX_i  input  1  div/divu in EX this cycle.
- hilo_read_IFID_i  input  1  mfhi/mflo decoded in ID.
- muldiv_IFID_i  input  1  mult/multu/div/divu decoded in ID.
- mdu_start_o  output  1  one-cycle start pulse to the MDU datapath.
- mdu_is_div_o  output  1  operation select, valid with mdu_start_o.
- mdu_busy_o  output  1  high in MUL or DIV state.
- hilo_write_o  output  1  one-cycle HI/LO register write enable.
- PC_write_o  output  1  0 = hold PC.
- IFID_write_o  output  1  0 = hold IF/ID.
- ctl_flush_o  output  1  0 = zero ID control signals (bubble).
- proto_err_o  output  1  sticky; start seen while busy or both starts together.
- stall_cnt_o  output  16  stall-cycle count (see Optional Feature).

Behaviour:
- Clock and reset: single clock domain. All state updates on the rising edge of clk. Reset is synchronous, active-high, and takes priority over everything else.
- Reset values: state=IDLE, cnt=0, proto_err_o=0, stall_cnt_o=0. The combinational outputs then resolve to mdu_busy_o=0, hilo_write_o=0, PC_write_o=1, IFID_write_o=1, ctl_flush_o=1.
- FSM states: IDLE, MUL, DIV, DONE.
- accept = state is IDLE or DONE, and (start_mul_IDEX_i or start_div_IDEX_i).
- mdu_start_o = accept (combinational).
- mdu_is_div_o = start_div_IDEX_i and not start_mul_IDEX_i.
- IDLE/DONE transitions:
  - start_mul -> MUL, cnt=MUL_CYCLES-1.
  - else start_div -> DIV, cnt=DIV_CYCLES-1.
  - else -> IDLE.
  - Both starts in the same cycle: mul wins and proto_err_o is set.
- MUL/DIV transitions: if cnt==0 -> DONE, else cnt decrements by 1. Starts seen in these states are ignored and set proto_err_o.
- DONE lasts exactly one cycle. hilo_write_o = (state==DONE).
- Latency: start at cycle N gives hilo_write_o at cycle N+MUL_CYCLES+1 (mul) or N+DIV_CYCLES+1 (div).
- Back-to-back: a start accepted in DONE goes directly to MUL/DIV with no IDLE cycle between.
- hazard = (hilo_read_IFID_i or muldiv_IFID_i) and (mdu_busy_o or accept).
- When hazard=1: PC_write_o=0, IFID_write_o=0, ctl_flush_o=0. Otherwise all three are 1.
- No stall in DONE unless a new start is accepted. HI/LO is written at the end of DONE, so an mfhi in ID during DONE reads the new value in EX next cycle.
- Reset mid-operation: returns to IDLE in the same edge. No hilo_write_o pulse; the pending result is discarded.
- proto_err_o clears only on reset.

Optional Feature:
- Macro: MUDIV_HAZARD_STALL_CNT_EN.
- Defined: 16-bit register increments on each clock where hazard=1. It saturates at 0xFFFF and clears on reset. stall_cnt_o shows the register.
- Undefined: no register is synthesized and stall_cnt_o is tied to 16'h0000.

Test Plan:
- Reset, hold 3 cycles, then no inputs -> mdu_busy_o=0, hilo_write_o=0, PC_write_o=1, IFID_write_o=1, ctl_flush_o=1, proto_err_o=0.
- start_mul_IDEX_i=1 at cycle 0, MUL_CYCLES=4 -> mdu_start_o=1 and mdu_is_div_o=0 at cycle 0; mdu_busy_o=1 cycles 1-4; hilo_write_o=1 only at cycle 5.
- start_div at cycle 0 with hilo_read_IFID_i=1 held -> PC_write_o=0 during cycles 0-32, 1 at cycle 33 (DONE); exactly one hilo_write_o, at cycle 33. With MUDIV_HAZARD_STALL_CNT_EN defined, stall_cnt_o=33.
- mult start, then a new start_div_IDEX_i during DONE -> hilo_write_o at cycle 5, mdu_start_o=1 and mdu_is_div_o=1 at cycle 5; DIV from cycle 6; second hilo_write_o at cycle 38.
- start_mul and start_div together at cycle 0 -> MUL path taken, proto_err_o=1 from cycle 1 and stays 1 until reset.
- div started, reset asserted at cycle 10 -> IDLE at cycle 11; no hilo_write_o through cycle 40; all stall outputs 1.

Source files
------------

// File: rtl/muldiv_hazard_ctrl.sv
// Sequencer and HI/LO hazard controller for the EX-stage multiply/divide unit.
// Latency: start at cycle N -> hilo_write_o at N+MUL_CYCLES+1 (mul) or N+DIV_CYCLES+1 (div).
// Backpressure: holds PC and IF/ID and bubbles ID while a HI/LO reader or MDU op in ID would race the unit.
// Optional stall-cycle counter enabled by defining MUDIV_HAZARD_STALL_CNT_EN.
module muldiv_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mul_IDEX_i,
    input  logic        start_div_IDEX_i,
    input  logic        hilo_read_IFID_i,
    input  logic        muldiv_IFID_i,
    output logic        mdu_start_o,
    output logic        mdu_is_div_o,
    output logic        mdu_busy_o,
    output logic        hilo_write_o,
    output logic        PC_write_o,
    output logic        IFID_write_o,
    output logic        ctl_flush_o,
    output logic        proto_err_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter preload values: the op state is held for exactly N cycles,
    // counting N-1 down to 0 before moving to DONE.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             proto_err_q, proto_err_d;

    logic any_start;
    logic ready;
    logic busy;
    logic accept;
    logic start_conflict;
    logic hazard;

    // Decode of the current state and the issue request.
    always_comb begin
        any_start = start_mul_IDEX_i | start_div_IDEX_i;
        ready     = (state_q == ST_IDLE) | (state_q == ST_DONE);
        busy      = (state_q == ST_MUL)  | (state_q == ST_DIV);
        accept    = ready & any_start;
        // Both starts together (mul wins) or any start while the unit is
        // still counting is a protocol violation by the issue logic.
        start_conflict = (ready & start_mul_IDEX_i & start_div_IDEX_i)
                       | (busy & any_start);
        // A HI/LO reader or another MDU op in ID must wait while the unit is
        // busy or is being started this cycle; DONE alone is safe because
        // HI/LO is written at the end of DONE, ahead of the reader's EX.
        hazard = (hilo_read_IFID_i | muldiv_IFID_i) & (busy | accept);
    end

    // Next-state logic for the sequencer, latency counter and sticky error.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q | start_conflict;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new op directly so back-to-back issue has
                // no idle gap between results.
                if (start_mul_IDEX_i) begin
                    state_d = ST_MUL;
                    cnt_d   = MUL_LOAD;
                end else if (start_div_IDEX_i) begin
                    state_d = ST_DIV;
                    cnt_d   = DIV_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef MUDIV_HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles in which the front end was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0000;
`endif

    // MDU handshake and HI/LO write enable.
    assign mdu_start_o  = accept;
    assign mdu_is_div_o = start_div_IDEX_i & ~start_mul_IDEX_i;
    assign mdu_busy_o   = busy;
    assign hilo_write_o = (state_q == ST_DONE);
    assign proto_err_o  = proto_err_q;

    // Stall controls are active-low, matching the load-use stall signals.
    assign PC_write_o   = ~hazard;
    assign IFID_write_o = ~hazard;
    assign ctl_flush_o  = ~hazard;

endmodule

// File: tb/tb_muldiv_hazard_ctrl.sv
// Self-checking bench for muldiv_hazard_ctrl.
// Per-cycle table of stimulus/expectation records plus hand-written multi-cycle sequences.
// HI/LO write timing is tracked by a scoreboard of expected write cycles.
module tb_muldiv_hazard_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;
    localparam int NV         = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mul_IDEX_i;
    logic        start_div_IDEX_i;
    logic        hilo_read_IFID_i;
    logic        muldiv_IFID_i;
    logic        mdu_start_o;
    logic        mdu_is_div_o;
    logic        mdu_busy_o;
    logic        hilo_write_o;
    logic        PC_write_o;
    logic        IFID_write_o;
    logic        ctl_flush_o;
    logic        proto_err_o;
    logic [15:0] stall_cnt_o;

    muldiv_hazard_ctrl #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_mul_IDEX_i(start_mul_IDEX_i),
        .start_div_IDEX_i(start_div_IDEX_i),
        .hilo_read_IFID_i(hilo_read_IFID_i),
        .muldiv_IFID_i   (muldiv_IFID_i),
        .mdu_start_o     (mdu_start_o),
        .mdu_is_div_o    (mdu_is_div_o),
        .mdu_busy_o      (mdu_busy_o),
        .hilo_write_o    (hilo_write_o),
        .PC_write_o      (PC_write_o),
        .IFID_write_o    (IFID_write_o),
        .ctl_flush_o     (ctl_flush_o),
        .proto_err_o     (proto_err_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Absolute cycle index; a cycle runs from one rising edge to the next.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: absolute cycle numbers at which hilo_write_o must pulse.
    int exp_q[$];

    typedef struct packed {
        logic sm;
        logic sd;
        logic hr;
        logic md;
        logic e_start;
        logic e_isdiv;
        logic e_busy;
        logic e_hilo;
        logic e_stall;
        logic e_err;
    } vec_t;

    vec_t tbl[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sm, input logic sd, input logic hr, input logic md);
        start_mul_IDEX_i = sm;
        start_div_IDEX_i = sd;
        hilo_read_IFID_i = hr;
        muldiv_IFID_i    = md;
    endtask

    task automatic chk_stall(input string name, input logic stalled);
        chk({name, " PC_write"},   {31'd0, PC_write_o},   {31'd0, ~stalled});
        chk({name, " IFID_write"}, {31'd0, IFID_write_o}, {31'd0, ~stalled});
        chk({name, " ctl_flush"},  {31'd0, ctl_flush_o},  {31'd0, ~stalled});
    endtask

    // Reset discards any pending result, so the scoreboard is emptied too.
    task automatic do_reset(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        repeat (n) next_cycle();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) next_cycle();
        chk({name, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    // Every observed HI/LO write must match the oldest expected write cycle.
    always @(negedge clk) begin
        if (hilo_write_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL hilo_write unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
                chk("hilo_write cycle", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vec_t v;

        // sm sd hr md | start isdiv busy hilo stall err
        tbl[0] = 10'b1001_100010; // mul issued with muldiv in ID -> stall
        tbl[1] = 10'b0000_001000; // busy, ID quiet
        tbl[2] = 10'b0010_001010; // mfhi in ID while busy -> stall
        tbl[3] = 10'b0001_001010; // mult in ID while busy -> stall
        tbl[4] = 10'b0000_001000; // last MUL cycle
        tbl[5] = 10'b0010_000100; // DONE: write, mfhi not stalled
        tbl[6] = 10'b0000_000000; // back to IDLE
        tbl[7] = 10'b0100_110000; // div issued, ID quiet
        tbl[8] = 10'b1000_001000; // start while busy: ignored
        tbl[9] = 10'b0001_001011; // error now sticky; stall for muldiv in ID

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        next_cycle();

        // Reset state.
        do_reset(3);
        @(negedge clk);
        chk("rst busy", {31'd0, mdu_busy_o}, 32'd0);
        chk("rst hilo", {31'd0, hilo_write_o}, 32'd0);
        chk("rst start", {31'd0, mdu_start_o}, 32'd0);
        chk("rst err", {31'd0, proto_err_o}, 32'd0);
        chk("rst stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
        chk_stall("rst", 1'b0);
        next_cycle();

        // Table-driven mul sequence followed by a div with a late start.
        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            drive(v.sm, v.sd, v.hr, v.md);
            if (v.e_start) exp_q.push_back(cyc + (v.e_isdiv ? DIV_CYCLES : MUL_CYCLES) + 1);
            @(negedge clk);
            chk($sformatf("tbl[%0d] start", i), {31'd0, mdu_start_o}, {31'd0, v.e_start});
            if (v.e_start) chk($sformatf("tbl[%0d] is_div", i), {31'd0, mdu_is_div_o}, {31'd0, v.e_isdiv});
            chk($sformatf("tbl[%0d] busy", i), {31'd0, mdu_busy_o}, {31'd0, v.e_busy});
            chk($sformatf("tbl[%0d] hilo", i), {31'd0, hilo_write_o}, {31'd0, v.e_hilo});
            chk($sformatf("tbl[%0d] err", i), {31'd0, proto_err_o}, {31'd0, v.e_err});
            chk_stall($sformatf("tbl[%0d]", i), v.e_stall);
            next_cycle();
        end
        wait_drain("tbl", 60);
        @(negedge clk);
        chk("tbl err sticky", {31'd0, proto_err_o}, 32'd1);
        next_cycle();

        // Div with mfhi held in ID: stalled through cycle 32, released in DONE.
        do_reset(2);
        for (int k = 0; k <= 34; k++) begin
            drive(1'b0, (k == 0), 1'b1, 1'b0);
            if (k == 0) exp_q.push_back(cyc + DIV_CYCLES + 1);
            @(negedge clk);
            if (k == 0) chk("div is_div", {31'd0, mdu_is_div_o}, 32'd1);
            chk_stall($sformatf("div k=%0d", k), (k <= DIV_CYCLES));
            if (k == DIV_CYCLES + 1) begin
`ifdef MUDIV_HAZARD_STALL_CNT_EN
                chk("div stall_cnt", {16'd0, stall_cnt_o}, DIV_CYCLES + 1);
`else
                chk("div stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
`endif
            end
            next_cycle();
        end
        wait_drain("div", 4);

        // Back-to-back: div accepted in the DONE cycle of a mul.
        do_reset(2);
        for (int k = 0; k <= 39; k++) begin
            drive((k == 0), (k == MUL_CYCLES + 1), 1'b0, 1'b0);
            if (k == 0) exp_q.push_back(cyc + MUL_CYCLES + 1);
            if (k == MUL_CYCLES + 1) exp_q.push_back(cyc + DIV_CYCLES + 1);
            @(negedge clk);
            chk($sformatf("b2b k=%0d busy", k), {31'd0, mdu_busy_o},
                {31'd0, ((k >= 1 && k <= MUL_CYCLES) || (k >= MUL_CYCLES + 2 && k <= MUL_CYCLES + 1 + DIV_CYCLES))});
            if (k == MUL_CYCLES + 1) begin
                chk("b2b start", {31'd0, mdu_start_o}, 32'd1);
                chk("b2b is_div", {31'd0, mdu_is_div_o}, 32'd1);
            end
            next_cycle();
        end
        wait_drain("b2b", 4);

        // Both starts together: mul wins, error sticky until reset.
        for (int k = 0; k <= 8; k++) begin
            drive((k == 0), (k == 0), 1'b0, 1'b0);
            if (k == 0) exp_q.push_back(cyc + MUL_CYCLES + 1);
            @(negedge clk);
            chk($sformatf("both k=%0d err", k), {31'd0, proto_err_o}, {31'd0, (k >= 1)});
            if (k == 0) chk("both is_div", {31'd0, mdu_is_div_o}, 32'd0);
            if (k == 1) chk("both mul path busy", {31'd0, mdu_busy_o}, 32'd1);
            next_cycle();
        end
        wait_drain("both", 4);
        do_reset(1);
        @(negedge clk);
        chk("err cleared by reset", {31'd0, proto_err_o}, 32'd0);
        next_cycle();

        // Reset in the middle of a div: result discarded, no write pulse.
        base = cyc;
        for (int k = 0; k <= 40; k++) begin
            drive(1'b0, (k == 0), (k > 10), 1'b0);
            reset = (k == 10);
            if (k == 0) exp_q.push_back(cyc + DIV_CYCLES + 1);
            if (k == 10) exp_q.delete();
            @(negedge clk);
            if (k == 5) chk("midrst busy before", {31'd0, mdu_busy_o}, 32'd1);
            if (k >= 11) begin
                chk($sformatf("midrst k=%0d busy", k), {31'd0, mdu_busy_o}, 32'd0);
                chk_stall($sformatf("midrst k=%0d", k), 1'b0);
            end
            next_cycle();
        end
        reset = 1'b0;
        chk("midrst span", cyc - base, 41);
        chk("final scoreboard empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
